// File: rtl/ifetch.sv
// Instruction fetch unit: issues sequential word reads to a synchronous instruction
// memory and buffers up to two returned words for decode, with redirect flush.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ncs,
  output logic        nwr,
  output logic [9:0]  addr,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  logic [31:0] pc;
  logic [31:0] tag;
  logic        inflight;
  logic [1:0]  count;
  logic [31:0] head_instr, head_pc;
  logic [31:0] tail_instr, tail_pc;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  unused_redirect_bits;

  assign unused_redirect_bits = redirect_pc[1:0];

  // Occupancy counts queued words plus the read still in flight, so the
  // queue can never overflow when the outstanding word arrives.
  assign pop       = instr_valid & instr_ready;
  assign push      = inflight & ~redirect;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = ~rst & ~redirect & (occupancy < 3'd2);

  assign ncs         = ~issue;
  assign nwr         = 1'b1;
  assign din         = 32'h0000_0000;
  assign addr        = pc[11:2];
  assign instr_valid = (count != 2'd0);
  assign instr       = head_instr;
  assign instr_pc    = head_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      tag      <= 32'h0000_0000;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc       <= pc + 32'd4;
      tag      <= pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  // Two-entry queue held as head/tail registers so decode always sees a
  // registered word rather than the raw memory bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      head_instr <= 32'h0000_0000;
      head_pc    <= 32'h0000_0000;
      tail_instr <= 32'h0000_0000;
      tail_pc    <= 32'h0000_0000;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= dout;
            head_pc    <= tag;
          end else begin
            tail_instr <= dout;
            tail_pc    <= tag;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_instr <= dout;
            head_pc    <= tag;
          end else begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= dout;
            tail_pc    <= tag;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
